// File: rtl/dsp_mac_slice.sv
// Parametrised multiply-accumulate slice: a pipelined A*B product feeds a
// framed accumulator with optional saturation and a sticky overflow flag.
module dsp_mac_slice #(
    parameter int A_WIDTH     = 18,
    parameter int B_WIDTH     = 18,
    parameter int P_WIDTH     = 48,
    parameter int PIPE_STAGES = 2,
    parameter bit SIGNED      = 1'b1,
    parameter bit SATURATE    = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ce,
    input  logic               i_in_valid,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [B_WIDTH-1:0] i_b,
    input  logic [P_WIDTH-1:0] i_c,
    input  logic               i_acc_clr,
    input  logic               i_acc_last,
    input  logic               i_sub,
    output logic [P_WIDTH-1:0] o_p,
    output logic               o_p_valid,
    output logic               o_ovf,
    output logic               o_busy
);
    localparam int M_WIDTH = A_WIDTH + B_WIDTH;
    localparam int L       = PIPE_STAGES;

    if (P_WIDTH < M_WIDTH + 1) begin : g_bad_pwidth
        $error("dsp_mac_slice: P_WIDTH must be >= A_WIDTH+B_WIDTH+1");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
        $error("dsp_mac_slice: PIPE_STAGES must be in 1..4");
    end

    // Operands extended to the full product width; the low M_WIDTH bits of
    // the product are exact for both signed and unsigned operands.
    logic [M_WIDTH-1:0] w_a_m, w_b_m, w_mul;
    logic [P_WIDTH-1:0] w_prod;

    assign w_a_m  = {{(M_WIDTH-A_WIDTH){SIGNED & i_a[A_WIDTH-1]}}, i_a};
    assign w_b_m  = {{(M_WIDTH-B_WIDTH){SIGNED & i_b[B_WIDTH-1]}}, i_b};
    assign w_mul  = w_a_m * w_b_m;
    assign w_prod = {{(P_WIDTH-M_WIDTH){SIGNED & w_mul[M_WIDTH-1]}}, w_mul};

    logic [L:1]              r_vld, r_clr, r_last, r_sub;
    logic [L:1][P_WIDTH-1:0] r_prod, r_c;
    logic [P_WIDTH-1:0]      r_acc, r_p;
    logic                    r_sticky, r_ovf, r_pv, r_open;

    logic [P_WIDTH-1:0] w_base, w_opnd, w_res, w_sat, w_acc_nxt;
    logic [P_WIDTH:0]   w_sum;
    logic               w_ovf_s, w_ovf_u, w_ovf, w_sticky_nxt;

    // Subtract is done as base + ~prod + 1 so one adder serves both.
    assign w_base  = r_clr[L] ? r_c[L] : r_acc;
    assign w_opnd  = r_sub[L] ? ~r_prod[L] : r_prod[L];
    assign w_sum   = {1'b0, w_base} + {1'b0, w_opnd} + (P_WIDTH+1)'(r_sub[L]);
    assign w_res   = w_sum[P_WIDTH-1:0];
    assign w_ovf_s = (w_base[P_WIDTH-1] == w_opnd[P_WIDTH-1]) &&
                     (w_res[P_WIDTH-1] != w_base[P_WIDTH-1]);
    assign w_ovf_u = w_sum[P_WIDTH] ^ r_sub[L];
    assign w_ovf   = SIGNED ? w_ovf_s : w_ovf_u;

    assign w_sat = SIGNED ?
                   (w_base[P_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}} : {1'b0, {(P_WIDTH-1){1'b1}}}) :
                   (r_sub[L] ? {P_WIDTH{1'b0}} : {P_WIDTH{1'b1}});
    assign w_acc_nxt    = (SATURATE && w_ovf) ? w_sat : w_res;
    assign w_sticky_nxt = (r_clr[L] ? 1'b0 : r_sticky) | w_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld    <= '0;
            r_clr    <= '0;
            r_last   <= '0;
            r_sub    <= '0;
            r_prod   <= '0;
            r_c      <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_p      <= '0;
            r_ovf    <= 1'b0;
            r_pv     <= 1'b0;
            r_open   <= 1'b0;
        end else if (i_ce) begin
            r_vld[1]  <= i_in_valid;
            r_clr[1]  <= i_in_valid & i_acc_clr;
            r_last[1] <= i_in_valid & i_acc_last;
            r_sub[1]  <= i_in_valid & i_sub;
            r_prod[1] <= w_prod;
            r_c[1]    <= i_c;
            for (int i = 2; i <= L; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_clr[i]  <= r_clr[i-1];
                r_last[i] <= r_last[i-1];
                r_sub[i]  <= r_sub[i-1];
                r_prod[i] <= r_prod[i-1];
                r_c[i]    <= r_c[i-1];
            end

            if (i_in_valid) begin
                if (i_acc_last)
                    r_open <= 1'b0;
                else if (i_acc_clr)
                    r_open <= 1'b1;
            end

            // r_pv only drops on a CE=1 edge, so a pulse stalled by CE=0 is
            // still emitted once when CE returns.
            r_pv <= 1'b0;
            if (r_vld[L]) begin
                r_acc    <= w_acc_nxt;
                r_sticky <= w_sticky_nxt;
                if (r_last[L]) begin
                    r_p   <= w_acc_nxt;
                    r_ovf <= w_sticky_nxt;
                    r_pv  <= 1'b1;
                end
            end
        end
    end

    assign o_p       = r_p;
    assign o_ovf     = r_ovf;
    assign o_p_valid = r_pv & i_ce;
    assign o_busy    = (|r_vld) | r_open;
endmodule

// File: tb/tb_dsp_mac_slice.sv
// Directed bench for dsp_mac_slice: three 40-bit instances (signed saturating,
// signed wrapping, unsigned saturating) share one stimulus stream.
module tb_dsp_mac_slice;
    localparam int AW = 18, BW = 18, PW = 40, PS = 2;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        logic [PW-1:0] c;
        logic          sub;
        logic [PW-1:0] p_s;
        logic          ov_s;
        logic [PW-1:0] p_w;
        logic          ov_w;
        logic [PW-1:0] p_u;
        logic          ov_u;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
    logic          in_valid = 1'b0, clr = 1'b0, last = 1'b0, sub = 1'b0;
    logic [AW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic [PW-1:0] c = '0;
    logic [PW-1:0] p_s, p_w, p_u;
    logic          pv_s, pv_w, pv_u, ov_s, ov_w, ov_u, bz_s, bz_w, bz_u;
    int            n_vec = 0, n_err = 0, cnt_s = 0, cnt_w = 0;

    always #5 clk = ~clk;

    dsp_mac_slice #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .PIPE_STAGES(PS),
                    .SIGNED(1'b1), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid),
        .i_a(a), .i_b(b), .i_c(c), .i_acc_clr(clr), .i_acc_last(last), .i_sub(sub),
        .o_p(p_s), .o_p_valid(pv_s), .o_ovf(ov_s), .o_busy(bz_s));

    dsp_mac_slice #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .PIPE_STAGES(PS),
                    .SIGNED(1'b1), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid),
        .i_a(a), .i_b(b), .i_c(c), .i_acc_clr(clr), .i_acc_last(last), .i_sub(sub),
        .o_p(p_w), .o_p_valid(pv_w), .o_ovf(ov_w), .o_busy(bz_w));

    dsp_mac_slice #(.A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .PIPE_STAGES(PS),
                    .SIGNED(1'b0), .SATURATE(1'b1)) u_uns (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_in_valid(in_valid),
        .i_a(a), .i_b(b), .i_c(c), .i_acc_clr(clr), .i_acc_last(last), .i_sub(sub),
        .o_p(p_u), .o_p_valid(pv_u), .o_ovf(ov_u), .o_busy(bz_u));

    // Pulse counters sample mid-cycle, well away from input changes.
    always @(negedge clk) begin
        if (pv_s) cnt_s++;
        if (pv_w) cnt_w++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic v, input logic cl, input logic la, input logic su,
                       input logic [AW-1:0] aa, input logic [BW-1:0] bb, input logic [PW-1:0] cc);
        in_valid = v; clr = cl; last = la; sub = su; a = aa; b = bb; c = cc;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        vec_t tbl[8];
        int   base_s, base_w;

        // One-sample runs (clr=last=1); 40-bit results per instance.
        tbl[0] = '{a:18'd6, b:18'd7, c:40'd100, sub:1'b1,
                   p_s:40'd58, ov_s:1'b0, p_w:40'd58, ov_w:1'b0, p_u:40'd58, ov_u:1'b0};
        tbl[1] = '{a:18'd5, b:18'd2, c:40'h7F_FFFF_FFF6, sub:1'b0,
                   p_s:40'h7F_FFFF_FFFF, ov_s:1'b1, p_w:40'h80_0000_0000, ov_w:1'b1,
                   p_u:40'h80_0000_0000, ov_u:1'b0};
        tbl[2] = '{a:18'd3, b:18'd4, c:40'd0, sub:1'b0,
                   p_s:40'd12, ov_s:1'b0, p_w:40'd12, ov_w:1'b0, p_u:40'd12, ov_u:1'b0};
        tbl[3] = '{a:18'd3, b:18'd4, c:40'h80_0000_0005, sub:1'b1,
                   p_s:40'h80_0000_0000, ov_s:1'b1, p_w:40'h7F_FFFF_FFF9, ov_w:1'b1,
                   p_u:40'h7F_FFFF_FFF9, ov_u:1'b0};
        tbl[4] = '{a:18'd3, b:18'd4, c:40'd5, sub:1'b1,
                   p_s:40'hFF_FFFF_FFF9, ov_s:1'b0, p_w:40'hFF_FFFF_FFF9, ov_w:1'b0,
                   p_u:40'd0, ov_u:1'b1};
        tbl[5] = '{a:18'd4, b:18'd5, c:40'hFF_FFFF_FFF0, sub:1'b0,
                   p_s:40'd4, ov_s:1'b0, p_w:40'd4, ov_w:1'b0,
                   p_u:40'hFF_FFFF_FFFF, ov_u:1'b1};
        tbl[6] = '{a:18'h3FFFE, b:18'd5, c:40'd0, sub:1'b0,
                   p_s:40'hFF_FFFF_FFF6, ov_s:1'b0, p_w:40'hFF_FFFF_FFF6, ov_w:1'b0,
                   p_u:40'h13_FFF6, ov_u:1'b0};
        tbl[7] = '{a:18'h3FFFD, b:18'h3FFFC, c:40'd1, sub:1'b0,
                   p_s:40'd13, ov_s:1'b0, p_w:40'd13, ov_w:1'b0,
                   p_u:40'h0F_FFE4_000D, ov_u:1'b0};

        // Reset state
        tick(); tick();
        chk("rst_p", p_s, 40'd0);
        chk("rst_ovf", {39'd0, ov_s}, 40'd0);
        chk("rst_pv", {39'd0, pv_s}, 40'd0);
        chk("rst_busy", {39'd0, bz_s | bz_w | bz_u}, 40'd0);
        rst_n = 1'b1;
        tick();

        // Reset mid-run flushes the in-flight clr sample
        base_s = cnt_s;
        put(1'b1, 1'b1, 1'b0, 1'b0, 18'd3, 18'd4, 40'd50);
        tick();
        idle();
        chk("busy_open", {39'd0, bz_s}, 40'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_p", p_s, 40'd0);
        chk("midrst_ovf", {39'd0, ov_s}, 40'd0);
        chk("midrst_busy", {39'd0, bz_s}, 40'd0);
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("midrst_no_pv", 40'(cnt_s - base_s), 40'd0);

        // Samples without a prior clr accumulate onto zero
        put(1'b1, 1'b0, 1'b1, 1'b0, 18'd2, 18'd3, 40'd77);
        tick(); idle(); tick(); tick();
        chk("noclr_pv", {39'd0, pv_s}, 40'd1);
        chk("noclr_p_s", p_s, 40'd6);
        chk("noclr_p_u", p_u, 40'd6);
        tick();

        // Signed dot product: 10 + 3*4 - 2*5 + 7*1 = 19
        base_s = cnt_s;
        put(1'b1, 1'b1, 1'b0, 1'b0, 18'd3, 18'd4, 40'd10);     tick();
        put(1'b1, 1'b0, 1'b0, 1'b0, 18'h3FFFE, 18'd5, 40'd0);  tick();
        put(1'b1, 1'b0, 1'b1, 1'b0, 18'd7, 18'd1, 40'd0);      tick();
        idle();
        chk("dot_pv_n1", {39'd0, pv_s}, 40'd0);
        tick();
        chk("dot_pv_n2", {39'd0, pv_s}, 40'd0);
        chk("dot_busy_n2", {39'd0, bz_s}, 40'd1);
        tick();
        chk("dot_pv_n3", {39'd0, pv_s}, 40'd1);
        chk("dot_p_s", p_s, 40'd19);
        chk("dot_p_w", p_w, 40'd19);
        chk("dot_p_u", p_u, 40'h14_0013);
        chk("dot_ovf", {39'd0, ov_s}, 40'd0);
        chk("dot_busy_n3", {39'd0, bz_s}, 40'd0);
        tick();
        chk("dot_pv_n4", {39'd0, pv_s}, 40'd0);
        chk("dot_hold", p_s, 40'd19);
        chk("dot_pulses", 40'(cnt_s - base_s), 40'd1);

        // Same run with CE low for 3 cycles after the second sample
        base_s = cnt_s;
        put(1'b1, 1'b1, 1'b0, 1'b0, 18'd3, 18'd4, 40'd10);     tick();
        put(1'b1, 1'b0, 1'b0, 1'b0, 18'h3FFFE, 18'd5, 40'd0);  tick();
        ce = 1'b0;
        put(1'b1, 1'b0, 1'b1, 1'b0, 18'd7, 18'd1, 40'd0);
        repeat (3) tick();
        chk("ce_busy_stall", {39'd0, bz_s}, 40'd1);
        ce = 1'b1;
        tick(); idle();
        tick();
        chk("ce_pv_early", {39'd0, pv_s}, 40'd0);
        tick();
        chk("ce_pv", {39'd0, pv_s}, 40'd1);
        chk("ce_p", p_s, 40'd19);
        tick();
        chk("ce_pulses", 40'(cnt_s - base_s), 40'd1);

        // CE dropped exactly when a pulse is due: emitted once on resumption
        base_s = cnt_s;
        put(1'b1, 1'b1, 1'b1, 1'b0, 18'd2, 18'd5, 40'd1);
        tick(); idle(); tick(); tick();
        ce = 1'b0;
        #1;
        chk("cehold_masked", {39'd0, pv_s}, 40'd0);
        tick(); tick();
        ce = 1'b1;
        #1;
        chk("cehold_pv", {39'd0, pv_s}, 40'd1);
        chk("cehold_p", p_s, 40'd11);
        tick();
        chk("cehold_pv_off", {39'd0, pv_s}, 40'd0);
        chk("cehold_pulses", 40'(cnt_s - base_s), 40'd1);

        // Back-to-back one-sample runs
        base_s = cnt_s;
        base_w = cnt_w;
        put(1'b1, 1'b1, 1'b1, 1'b0, 18'd2, 18'd3, 40'd0); tick();
        put(1'b1, 1'b1, 1'b1, 1'b0, 18'd4, 18'd4, 40'd1); tick();
        idle(); tick();
        chk("b2b_pv1", {39'd0, pv_s}, 40'd1);
        chk("b2b_p1", p_s, 40'd6);
        tick();
        chk("b2b_pv2", {39'd0, pv_s}, 40'd1);
        chk("b2b_p2", p_s, 40'd17);
        tick(); tick();
        chk("b2b_pv_off", {39'd0, pv_s}, 40'd0);
        chk("b2b_hold", p_s, 40'd17);
        chk("b2b_pulses_s", 40'(cnt_s - base_s), 40'd2);
        chk("b2b_pulses_w", 40'(cnt_w - base_w), 40'd2);

        // Sticky overflow survives a later clean sample in the same run
        put(1'b1, 1'b1, 1'b0, 1'b0, 18'd5, 18'd2, 40'h7F_FFFF_FFF6); tick();
        put(1'b1, 1'b0, 1'b1, 1'b1, 18'd1, 18'd1, 40'd0);            tick();
        idle(); tick(); tick();
        chk("sticky_p_s", p_s, 40'h7F_FFFF_FFFE);
        chk("sticky_ov_s", {39'd0, ov_s}, 40'd1);
        chk("sticky_p_w", p_w, 40'h7F_FFFF_FFFF);
        chk("sticky_ov_w", {39'd0, ov_w}, 40'd1);
        chk("sticky_p_u", p_u, 40'h7F_FFFF_FFFF);
        chk("sticky_ov_u", {39'd0, ov_u}, 40'd0);
        tick();

        // Table of one-sample runs
        for (int i = 0; i < 8; i++) begin
            put(1'b1, 1'b1, 1'b1, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].c);
            tick(); idle(); tick(); tick();
            chk($sformatf("v%0d_pv", i), {39'd0, pv_s & pv_w & pv_u}, 40'd1);
            chk($sformatf("v%0d_p_sat", i), p_s, tbl[i].p_s);
            chk($sformatf("v%0d_ov_sat", i), {39'd0, ov_s}, {39'd0, tbl[i].ov_s});
            chk($sformatf("v%0d_p_wrap", i), p_w, tbl[i].p_w);
            chk($sformatf("v%0d_ov_wrap", i), {39'd0, ov_w}, {39'd0, tbl[i].ov_w});
            chk($sformatf("v%0d_p_uns", i), p_u, tbl[i].p_u);
            chk($sformatf("v%0d_ov_uns", i), {39'd0, ov_u}, {39'd0, tbl[i].ov_u});
            tick();
        end

        chk("end_busy", {39'd0, bz_s | bz_w | bz_u}, 40'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_mac_slice.md
# dsp_mac_slice

Parametrised multiply-accumulate slice, successor to the fixed 18x18 DSP slice. It is generic in operand and accumulator width and in multiplier pipeline depth. Over the fixed slice it adds framed accumulation runs with a valid handshake, signed or unsigned arithmetic, optional saturation and a sticky overflow flag. It sits in the datapath wherever FIR taps, dot products or running sums are built, and is fed directly by upstream sample logic.

## Interface
- A_WIDTH, 18: multiplier operand A width.
- B_WIDTH, 18: multiplier operand B width.
- P_WIDTH, 48: accumulator, C and P width. Must satisfy P_WIDTH >= A_WIDTH+B_WIDTH+1 (elaboration error otherwise).
- PIPE_STAGES, 2: product register stages, range 1..4.
- SIGNED, 1: 1 = two's-complement operands, C and P; 0 = unsigned.
- SATURATE, 0: 1 = clamp accumulator on overflow; 0 = wrap.
- CLK  in  1  clock; all registers on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CE  in  1  global clock enable; 0 freezes all state.
- IN_VALID  in  1  sample present on A/B/C/control this cycle.
- A  in  A_WIDTH  multiplicand.
- B  in  B_WIDTH  multiplier.
- C  in  P_WIDTH  run start value; sampled only with ACC_CLR.
- ACC_CLR  in  1  first sample of a run; accumulator restarts from C.
- ACC_LAST  in  1  final sample of a run.
- SUB  in  1  1 = subtract this product, 0 = add.
- P  out  P_WIDTH  result of the last completed run.
- P_VALID  out  1  one-cycle pulse when P updates.
- OVF  out  1  overflow occurred in the run reported by P.
- BUSY  out  1  pipeline holds a valid sample, or a run is open (ACC_CLR seen, ACC_LAST not yet).

## Operation
- A sample is accepted when IN_VALID=1 and CE=1. ACC_CLR, ACC_LAST, SUB and C are ignored when IN_VALID=0.
- Product A*B is formed at full width A_WIDTH+B_WIDTH.
  - It is sign-extended when SIGNED=1 and zero-extended when SIGNED=0, to P_WIDTH.
- The product passes through PIPE_STAGES registers. Valid, clr, last, sub and C travel alongside it.
- Accumulator stage, on a valid pipeline sample:
  - base = C if clr, else acc.
  - acc <= base + prod, or base - prod if sub.
- Overflow detection:
  - Signed: operands of the effective add have the same sign and the result sign differs.
  - Unsigned: carry out on add, or borrow on subtract.
- Saturation, when SATURATE=1 and overflow occurs:
  - Signed: acc clamps to 2^(P_WIDTH-1)-1 on positive overflow, or -2^(P_WIDTH-1) on negative overflow.
  - Unsigned: acc clamps to 2^P_WIDTH-1 on carry, or 0 on borrow.
  - When SATURATE=0, the result wraps modulo 2^P_WIDTH.
- Internal sticky overflow:
  - Cleared by a clr sample, then set by that sample's own overflow.
  - Otherwise it ORs in each sample's overflow.
- On a sample with last=1: P <= new acc, OVF <= new sticky value, and P_VALID=1 for the next cycle.
- A sample with clr=1 and last=1 together is a one-sample run: P = C ± A*B.
- Samples arriving after reset without any prior clr accumulate onto acc=0.

## Timing
- Reset: all outputs are 0; acc, sticky and every pipeline valid are 0. The run-open flag is 0.
- Reset asserted mid-run flushes every in-flight sample; no P_VALID follows.
- Latency: ACC_LAST accepted in cycle n gives P/P_VALID visible in cycle n+PIPE_STAGES+1.
- Throughput: one sample per cycle, no bubbles. Back-to-back runs are allowed: a clr may follow a last in the very next cycle.
- CE=0: every register holds except P_VALID, which is forced to 0.
  - A pulse that was due is emitted once on the first CE=1 cycle after resumption. It is never duplicated.
- P and OVF hold between P_VALID pulses.
- BUSY is combinational from registered state. It falls in the cycle P_VALID rises, if no further samples are in flight.

## Test plan
- Reset mid-run: PIPE_STAGES=2, accept clr sample A=3,B=4, pull RST_N low next cycle, then release.
  -> P=0, OVF=0, BUSY=0 immediately; no P_VALID ever appears.
- Dot product, signed, PIPE_STAGES=2:
  - Stimulus: clr sample C=10,A=3,B=4; then A=-2,B=5; then last sample A=7,B=1 in cycle n.
  - Response: P=19, OVF=0, P_VALID single pulse in cycle n+3.
- Single-sample subtract: clr=last=1, SUB=1, C=100, A=6, B=7.
  -> P=58, one P_VALID.
- Saturation, signed, P_WIDTH=40:
  - Stimulus: clr=last=1, C=2^39-10, A=5, B=2.
  - SATURATE=1 -> P=2^39-1, OVF=1. SATURATE=0 -> P=-2^39, OVF=1.
  - A following clean run -> OVF=0.
- CE stall: repeat the dot-product run, dropping CE for 3 cycles after the second sample.
  -> P=19, pulse in cycle n+6, exactly one pulse.
- Back-to-back runs:
  - Stimulus: run1 (clr+last, C=0, A=2, B=3) and run2 (clr+last, C=1, A=4, B=4) in consecutive cycles.
  - Response: P_VALID high two consecutive cycles, with P=6 then P=17.
